dist_sched: RTL and testbench

//  Scheduler directly upstream of the distribution crossbar (xbar). Accepts beats of INPUT_BW

---
 rtl/dist_sched_pkg.sv | 8 +
 rtl/dist_lane_arbiter.sv | 24 ++
 rtl/dist_sched.sv | 82 ++++++++
 tb/tb_dist_sched.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dist_sched_pkg.sv
// dist_sched_pkg: FSM encoding and default widths shared across the distribution path
package dist_sched_pkg;
  typedef enum logic {DS_IDLE = 1'b0, DS_ISSUE = 1'b1} ds_state_t;
  localparam int DS_DATA_TYPE = 16;
  localparam int DS_NUM_PES   = 32;
  localparam int DS_INPUT_BW  = 32;
  localparam int DS_LOG2_PES  = 5;
endpackage

// File: rtl/dist_lane_arbiter.sv
// dist_lane_arbiter: grants the lowest-index pending lane targeting one PE
module dist_lane_arbiter
  import dist_sched_pkg::*;
#(
  parameter int INPUT_BW = DS_INPUT_BW,
  parameter int LOG2_PES = DS_LOG2_PES
) (
  input  logic [INPUT_BW-1:0]          pending,
  input  logic [INPUT_BW*LOG2_PES-1:0] dest_bus,
  input  logic [LOG2_PES-1:0]          pe_idx,
  output logic                         gnt_valid,
  output logic [LOG2_PES-1:0]          sel,
  output logic [INPUT_BW-1:0]          lane_gnt
);
  logic [INPUT_BW-1:0] match;
  always_comb begin
    match = '0;
    sel   = '0;
    for (int l = 0; l < INPUT_BW; l++) match[l] = pending[l] && dest_bus[l*LOG2_PES +: LOG2_PES] == pe_idx;
    for (int l = INPUT_BW - 1; l >= 0; l--) sel = match[l] ? LOG2_PES'(l) : sel;
  end
  assign gnt_valid = |match;
  assign lane_gnt  = match & (~match + INPUT_BW'(1));
endmodule

// File: rtl/dist_sched.sv
// dist_sched: serialises tagged lanes into per-PE crossbar selects with aligned valids
module dist_sched
  import dist_sched_pkg::*;
#(
  parameter int DATA_TYPE = DS_DATA_TYPE,
  parameter int NUM_PES   = DS_NUM_PES,
  parameter int INPUT_BW  = DS_INPUT_BW,
  parameter int LOG2_PES  = DS_LOG2_PES
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          i_valid,
  output logic                          o_ready,
  input  logic [INPUT_BW*DATA_TYPE-1:0] i_data_bus,
  input  logic [INPUT_BW-1:0]           i_lane_valid,
  input  logic [INPUT_BW*LOG2_PES-1:0]  i_dest_bus,
  output logic [INPUT_BW*DATA_TYPE-1:0] o_data_bus,
  output logic [NUM_PES*LOG2_PES-1:0]   o_mux_bus,
  output logic [NUM_PES-1:0]            o_sel_valid,
  output logic [NUM_PES-1:0]            o_pe_valid,
  output logic                          o_busy,
  output logic                          o_dest_err
);
  ds_state_t state, next_state;
  logic [INPUT_BW-1:0] pending, pending_left, acc_pend, gnt_or, dest_ok;
  logic [INPUT_BW-1:0] lane_gnt [NUM_PES];
  logic [INPUT_BW*DATA_TYPE-1:0] held_data;
  logic [INPUT_BW*LOG2_PES-1:0] held_dest;
  logic [NUM_PES*LOG2_PES-1:0] mux_next;
  logic [NUM_PES-1:0] gnt_valid;
  logic issuing, accept;
  genvar p;
  generate
    for (p = 0; p < NUM_PES; p++) begin : g_arb
      dist_lane_arbiter #(.INPUT_BW(INPUT_BW), .LOG2_PES(LOG2_PES)) u_arb (
        .pending  (pending),
        .dest_bus (held_dest),
        .pe_idx   (LOG2_PES'(p)),
        .gnt_valid(gnt_valid[p]),
        .sel      (mux_next[p*LOG2_PES +: LOG2_PES]),
        .lane_gnt (lane_gnt[p])
      );
    end
  endgenerate
  always_comb begin
    gnt_or  = '0;
    dest_ok = '0;
    for (int q = 0; q < NUM_PES; q++) gnt_or |= lane_gnt[q];
    for (int l = 0; l < INPUT_BW; l++) dest_ok[l] = int'(i_dest_bus[l*LOG2_PES +: LOG2_PES]) < NUM_PES;
  end
  assign issuing      = state == DS_ISSUE;
  assign pending_left = pending & ~gnt_or;
  assign acc_pend     = i_lane_valid & dest_ok;
  assign accept       = i_valid && o_ready && !rst;
  always_ff @(posedge clk) state <= rst ? DS_IDLE : next_state;
  always_comb next_state = accept ? (|acc_pend ? DS_ISSUE : DS_IDLE) : (issuing && |pending_left ? DS_ISSUE : DS_IDLE);
  always_comb begin
    o_ready = !issuing || pending_left == '0;
    o_busy  = issuing || |o_sel_valid || |o_pe_valid;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      pending     <= '0;
      held_data   <= '0;
      held_dest   <= '0;
      o_data_bus  <= '0;
      o_mux_bus   <= '0;
      o_sel_valid <= '0;
      o_pe_valid  <= '0;
      o_dest_err  <= 1'b0;
    end else begin
      o_pe_valid  <= o_sel_valid;
      o_sel_valid <= issuing ? gnt_valid : '0;
      o_mux_bus   <= issuing ? mux_next : o_mux_bus;
      o_data_bus  <= issuing ? held_data : o_data_bus;
      pending     <= accept ? acc_pend : pending_left;
      held_data   <= accept ? i_data_bus : held_data;
      held_dest   <= accept ? i_dest_bus : held_dest;
      o_dest_err  <= o_dest_err || (accept && |(i_lane_valid & ~dest_ok));
    end
  end
endmodule

// File: tb/tb_dist_sched.sv
// tb_dist_sched: table, directed and randomized checks of dist_sched against a queue model
module tb_dist_sched;
  localparam int DT = 16, NP = 32, BW = 32, LP = 5, NP24 = 24;
  logic clk = 0, rst = 1, i_valid = 0;
  logic [BW*DT-1:0] i_data_bus = '0;
  logic [BW-1:0] i_lane_valid = '0;
  logic [BW*LP-1:0] i_dest_bus = '0;
  logic o_ready, o_busy, o_dest_err;
  logic [BW*DT-1:0] o_data_bus;
  logic [NP*LP-1:0] o_mux_bus;
  logic [NP-1:0] o_sel_valid, o_pe_valid;
  logic ready24, busy24, err24;
  logic [BW*DT-1:0] data24;
  logic [NP24*LP-1:0] mux24;
  logic [NP24-1:0] sel24, pe24;
  always #5 clk = ~clk;
  dist_sched #(.DATA_TYPE(DT), .NUM_PES(NP), .INPUT_BW(BW), .LOG2_PES(LP)) u_dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready(o_ready), .i_data_bus(i_data_bus),
    .i_lane_valid(i_lane_valid), .i_dest_bus(i_dest_bus), .o_data_bus(o_data_bus),
    .o_mux_bus(o_mux_bus), .o_sel_valid(o_sel_valid), .o_pe_valid(o_pe_valid),
    .o_busy(o_busy), .o_dest_err(o_dest_err)
  );
  dist_sched #(.DATA_TYPE(DT), .NUM_PES(NP24), .INPUT_BW(BW), .LOG2_PES(LP)) u_dut24 (
    .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready(ready24), .i_data_bus(i_data_bus),
    .i_lane_valid(i_lane_valid), .i_dest_bus(i_dest_bus), .o_data_bus(data24),
    .o_mux_bus(mux24), .o_sel_valid(sel24), .o_pe_valid(pe24),
    .o_busy(busy24), .o_dest_err(err24)
  );
  int n_vec = 0, n_err = 0;
  task automatic chk(input string nm, input logic [511:0] got, input logic [511:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h expected %0h", nm, got, exp);
    end
  endtask
  typedef struct {
    logic [NP-1:0]    mask;
    logic [NP*LP-1:0] mux;
    logic [BW*DT-1:0] data;
  } rec_t;
  rec_t q[$];
  logic [NP-1:0] e_sel = '0, e_pe = '0;
  logic [NP*LP-1:0] e_mux = '0;
  logic [BW*DT-1:0] e_data = '0;
  logic e_err = 0;
  task automatic model_edge();
    rec_t r;
    rec_t rs[BW];
    int cnt[NP];
    int n, d;
    logic acc;
    if (rst) begin
      q.delete();
      e_sel = '0;
      e_pe = '0;
      e_mux = '0;
      e_data = '0;
      e_err = 0;
    end else begin
      acc = i_valid && q.size() <= 1;
      e_pe = e_sel;
      if (q.size() > 0) begin
        r = q.pop_front();
        e_sel = r.mask;
        e_mux = r.mux;
        e_data = r.data;
      end else e_sel = '0;
      if (acc) begin
        n = 0;
        foreach (cnt[k]) cnt[k] = 0;
        foreach (rs[k]) begin
          rs[k].mask = '0;
          rs[k].mux = '0;
          rs[k].data = i_data_bus;
        end
        for (int l = 0; l < BW; l++) if (i_lane_valid[l]) begin
          d = int'(i_dest_bus[l*LP +: LP]);
          if (d >= NP) e_err = 1;
          else begin
            rs[cnt[d]].mask[d] = 1'b1;
            rs[cnt[d]].mux[d*LP +: LP] = LP'(l);
            cnt[d]++;
            if (cnt[d] > n) n = cnt[d];
          end
        end
        for (int k = 0; k < n; k++) q.push_back(rs[k]);
      end
    end
  endtask
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("sel_valid", o_sel_valid, e_sel);
    chk("mux_bus", o_mux_bus, e_mux);
    chk("data_bus", o_data_bus, e_data);
    chk("pe_valid", o_pe_valid, e_pe);
    chk("ready", o_ready, q.size() <= 1);
    chk("busy", o_busy, q.size() > 0 || e_sel != '0 || e_pe != '0);
    chk("dest_err", o_dest_err, e_err);
  endtask
  task automatic set_beat(input logic [BW-1:0] lv, input int mul, input int add, input int md, input int base);
    for (int l = 0; l < BW; l++) begin
      i_data_bus[l*DT +: DT] = DT'(base + l);
      i_dest_bus[l*LP +: LP] = LP'((l * mul + add) % md);
    end
    i_lane_valid = lv;
  endtask
  typedef struct {
    logic [BW-1:0] lv;
    int mul, add, md;
    int exp_n;
    logic [NP-1:0] exp_mask;
    int exp_low;
  } vec_t;
  vec_t tbl[7];
  initial begin
    tbl[0] = '{32'hFFFF_FFFF, 1, 0, 32, 1, 32'hFFFF_FFFF, 0};
    tbl[1] = '{32'h0000_0089, 0, 4, 32, 3, 32'h0000_0010, 2};
    tbl[2] = '{32'h0000_0000, 1, 0, 32, 0, 32'h0000_0000, 0};
    tbl[3] = '{32'hFFFF_FFFF, 1, 0, 16, 2, 32'h0000_FFFF, 1};
    tbl[4] = '{32'h0000_000F, 0, 9, 32, 4, 32'h0000_0200, 3};
    tbl[5] = '{32'hFFFF_FFFF, 31, 31, 32, 1, 32'hFFFF_FFFF, 0};
    tbl[6] = '{32'hFFFF_0000, 1, 0, 2, 8, 32'h0000_0003, 7};
    set_beat('1, 1, 0, 32, 100);
    i_valid = 1;
    rst = 1;
    repeat (3) step();
    chk("rst_ready", o_ready, 1);
    chk("rst_busy", o_busy, 0);
    rst = 0;
    step();
    chk("first_accept", o_busy, 1);
    i_valid = 0;
    step();
    chk("id_mux5", o_mux_bus[5*LP +: LP], 5);
    chk("id_pe5_data", o_data_bus[5*DT +: DT], 105);
    chk("id_sel", o_sel_valid, 32'hFFFF_FFFF);
    step();
    chk("id_pe_valid", o_pe_valid, 32'hFFFF_FFFF);
    repeat (2) step();
    set_beat(32'h89, 0, 4, 32, 0);
    i_valid = 1;
    step();
    i_valid = 0;
    step();
    chk("cf_sel_a", o_mux_bus[4*LP +: LP], 0);
    chk("cf_mask_a", o_sel_valid, 32'h10);
    step();
    chk("cf_sel_b", o_mux_bus[4*LP +: LP], 3);
    step();
    chk("cf_sel_c", o_mux_bus[4*LP +: LP], 7);
    chk("cf_mask_c", o_sel_valid, 32'h10);
    step();
    chk("cf_done", o_sel_valid, 0);
    step();
    set_beat('1, 1, 0, 32, 200);
    i_valid = 1;
    step();
    set_beat('1, 31, 31, 32, 300);
    step();
    i_valid = 0;
    chk("b2b_first", o_sel_valid, 32'hFFFF_FFFF);
    step();
    chk("b2b_second", o_sel_valid, 32'hFFFF_FFFF);
    chk("b2b_mux0", o_mux_bus[0 +: LP], 31);
    repeat (2) step();
    for (int t = 0; t < 7; t++) begin
      int cnt, low;
      logic [NP-1:0] first;
      set_beat(tbl[t].lv, tbl[t].mul, tbl[t].add, tbl[t].md, 1000 * t);
      i_valid = 1;
      step();
      i_valid = 0;
      cnt = 0;
      first = '0;
      low = o_ready ? 0 : 1;
      for (int c = 0; c < 12; c++) begin
        step();
        if (o_sel_valid != '0) begin
          if (cnt == 0) first = o_sel_valid;
          cnt++;
        end
        if (!o_ready) low++;
      end
      chk($sformatf("tbl%0d_issues", t), cnt, tbl[t].exp_n);
      chk($sformatf("tbl%0d_mask", t), first, tbl[t].exp_mask);
      chk($sformatf("tbl%0d_ready_low", t), low, tbl[t].exp_low);
    end
    set_beat(32'h89, 0, 4, 32, 0);
    i_valid = 1;
    step();
    i_valid = 0;
    step();
    chk("rm_first", o_sel_valid, 32'h10);
    rst = 1;
    step();
    chk("rm_pe_valid", o_pe_valid, 0);
    chk("rm_sel", o_sel_valid, 0);
    rst = 0;
    step();
    chk("rm_ready", o_ready, 1);
    chk("rm_busy", o_busy, 0);
    step();
    chk("rm_no_issue", o_sel_valid, 0);
    rst = 1;
    step();
    rst = 0;
    set_beat(32'h6, 0, 0, 32, 500);
    i_dest_bus[1*LP +: LP] = LP'(3);
    i_dest_bus[2*LP +: LP] = LP'(30);
    i_valid = 1;
    step();
    i_valid = 0;
    chk("d24_err_rise", err24, 1);
    step();
    chk("d24_sel", sel24, 24'h8);
    chk("d24_mux3", mux24[3*LP +: LP], 1);
    repeat (3) step();
    chk("d24_err_hold", err24, 1);
    chk("d24_idle", busy24, 0);
    rst = 1;
    step();
    rst = 0;
    chk("d24_err_clr", err24, 0);
    for (int it = 0; it < 400; it++) begin
      int m;
      m = $urandom_range(1, 32);
      for (int l = 0; l < BW; l++) begin
        i_data_bus[l*DT +: DT] = DT'($urandom);
        i_dest_bus[l*LP +: LP] = LP'($urandom_range(0, m - 1));
        i_lane_valid[l] = $urandom_range(0, 3) != 0;
      end
      if ($urandom_range(0, 15) == 0) i_lane_valid = '0;
      i_valid = $urandom_range(0, 3) != 0;
      rst = $urandom_range(0, 99) == 0;
      step();
    end
    rst = 0;
    i_valid = 0;
    repeat (12) step();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
